// File: rtl/iter_divider_rk.sv
// iter_divider_rk: iterative integer divider/remainder retiring K quotient bits per cycle, with early-out and RISC-V special cases.
// Define DIVIDER_RESULT_CACHE_EN to add a one-entry cache that lets a repeated divide skip iteration.
module iter_divider_rk #(
   parameter int W = 64,
   parameter int K = 1,
   parameter int LG_ROB = 6,
   parameter int LG_PRF = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              start_div,
   input  logic [W-1:0]      inA,
   input  logic [W-1:0]      inB,
   input  logic              is_signed_div,
   input  logic              is_rem,
   input  logic              is_w,
   input  logic [LG_ROB-1:0] rob_ptr_in,
   input  logic [LG_PRF-1:0] prf_ptr_in,
   input  logic              wb_slot_used,
   output logic              ready,
   output logic              complete,
   output logic [W-1:0]      y,
   output logic [LG_ROB-1:0] rob_ptr_out,
   output logic [LG_PRF-1:0] prf_ptr_out
);
   localparam int CW = $clog2(W) + 1;
   localparam int LK = $clog2(K);

   typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIXUP, WAIT_WB} state_t;
   state_t state, next_state;

   logic [W-1:0]   a_ext, b_ext, a_abs, b_abs;
   logic           sa, sb;
   logic [W-1:0]   a_val, b_val, a_mag, d;
   logic           sgn, rem_f, w_f, qsign, rsign;
   logic [2*W-1:0] rr, rr_n;
   logic [W-1:0]   q, q_n;
   logic [W:0]     t;
   logic           ge;
   logic [CW-1:0]  cnt, lz, shamt, iters;
   logic [W-1:0]   min_val, r_hi, q_fix, r_fix, res, res_x;
   logic           div0, ovf, zero, hit;
   logic [W-1:0]   hit_q, hit_r;

   always_comb begin
      a_ext = is_w ? {{(W-32){is_signed_div & inA[31]}}, inA[31:0]} : inA;
      b_ext = is_w ? {{(W-32){is_signed_div & inB[31]}}, inB[31:0]} : inB;
      sa = is_signed_div & a_ext[W-1];
      sb = is_signed_div & b_ext[W-1];
      a_abs = sa ? -a_ext : a_ext;
      b_abs = sb ? -b_ext : b_ext;
   end

   // Pre-shift is clz rounded down to a multiple of K so a ragged top group lands first.
   always_comb begin
      lz = CW'(W);
      for (int i = 0; i < W; i++)
         if (a_mag[i]) lz = CW'(W - 1 - i);
      shamt = lz & ~CW'(K - 1);
      iters = (CW'(W) - shamt) >> LK;
   end

   always_comb begin
      min_val = w_f ? {{(W-31){1'b1}}, {31{1'b0}}} : {1'b1, {(W-1){1'b0}}};
      div0 = b_val == '0;
      ovf = sgn & (a_val == min_val) & (&b_val);
      zero = a_mag == '0;
   end

   // K restoring steps; t is the shifted partial remainder, one bit wider than D.
   always_comb begin
      rr_n = rr;
      q_n = q;
      t = '0;
      ge = 1'b0;
      for (int i = 0; i < K; i++) begin
         t = rr_n[2*W-1:W-1];
         ge = t >= {1'b0, d};
         t = ge ? t - {1'b0, d} : t;
         rr_n = {t[W-1:0], rr_n[W-2:0], 1'b0};
         q_n = {q_n[W-2:0], ge};
      end
   end

   always_comb begin
      r_hi = rr[2*W-1:W];
      q_fix = (sgn & qsign) ? -q : q;
      r_fix = (sgn & rsign) ? -r_hi : r_hi;
      res = rem_f ? r_fix : q_fix;
      res_x = w_f ? {{(W-32){res[31]}}, res[31:0]} : res;
   end

`ifdef DIVIDER_RESULT_CACHE_EN
   logic          c_valid, c_s, c_w;
   logic [W-1:0]  c_a, c_b, c_q, c_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_valid <= 1'b0;
         c_s <= 1'b0;
         c_w <= 1'b0;
         c_a <= '0;
         c_b <= '0;
         c_q <= '0;
         c_r <= '0;
      end else if (state == DIVIDE && cnt == CW'(1) && !flush) begin
         c_valid <= 1'b1;
         c_s <= sgn;
         c_w <= w_f;
         c_a <= a_mag;
         c_b <= d;
         c_q <= q_n;
         c_r <= rr_n[2*W-1:W];
      end
   end

   assign hit = c_valid & (c_a == a_mag) & (c_b == d) & (c_s == sgn) & (c_w == w_f);
   assign hit_q = c_q;
   assign hit_r = c_r;
`else
   assign hit = 1'b0;
   assign hit_q = '0;
   assign hit_r = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = (start_div & !flush) ? PREP : IDLE;
         PREP:    next_state = (div0 | ovf) ? WAIT_WB : (zero | hit) ? FIXUP : DIVIDE;
         DIVIDE:  next_state = (cnt == CW'(1)) ? FIXUP : DIVIDE;
         FIXUP:   next_state = WAIT_WB;
         WAIT_WB: next_state = wb_slot_used ? WAIT_WB : IDLE;
         default: next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   always_comb begin
      ready = (state == IDLE) & !start_div;
      complete = (state == WAIT_WB) & !wb_slot_used & !flush;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_val <= '0;
         b_val <= '0;
         a_mag <= '0;
         d <= '0;
         sgn <= 1'b0;
         rem_f <= 1'b0;
         w_f <= 1'b0;
         qsign <= 1'b0;
         rsign <= 1'b0;
         rr <= '0;
         q <= '0;
         cnt <= '0;
         y <= '0;
         rob_ptr_out <= '0;
         prf_ptr_out <= '0;
      end else begin
         case (state)
            IDLE: if (start_div & !flush) begin
               a_val <= a_ext;
               b_val <= b_ext;
               a_mag <= a_abs;
               d <= b_abs;
               sgn <= is_signed_div;
               rem_f <= is_rem;
               w_f <= is_w;
               qsign <= sa ^ sb;
               rsign <= sa;
               rob_ptr_out <= rob_ptr_in;
               prf_ptr_out <= prf_ptr_in;
            end
            PREP: if (div0) y <= rem_f ? a_val : '1;
               else if (ovf) y <= rem_f ? '0 : a_val;
               else if (zero) begin
                  rr <= '0;
                  q <= '0;
               end else if (hit) begin
                  rr <= {hit_r, {W{1'b0}}};
                  q <= hit_q;
               end else begin
                  rr <= {{W{1'b0}}, a_mag} << shamt;
                  q <= '0;
                  cnt <= iters;
               end
            DIVIDE: begin
               rr <= rr_n;
               q <= q_n;
               cnt <= cnt - CW'(1);
            end
            FIXUP: y <= res_x;
            default: ;
         endcase
      end
   end
endmodule
